// File: rtl/detector_riesgos.sv
// ---------------------------------------------------------------------------
// detector_riesgos
//
// Hazard detection and pipeline control for the filter processor pipeline.
// It resolves the hazards that forwarding cannot: load-use dependencies,
// taken branches resolved in Exe, and multi-cycle data-memory reads. It also
// keeps a sticky memory-timeout flag and two saturating performance counters.
//
// Parameters
//   TIMEOUT  consecutive memory-wait cycles tolerated before mem_error (1..255)
//   CNT_W    width of the performance counters
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   Ra_Dec/RE_A_Dec             decode source A and its read enable
//   Rb_Dec/RE_B_Dec             decode source B and its read enable
//   Robj_Reg_Exe/WE_Reg_Exe     Exe destination and its write enable
//   mem_RE_Reg_Exe              Exe instruction is a load
//   branch_taken_Exe            branch in Exe resolved taken
//   mem_RE_Exe_Mem, mem_ready   Mem-stage load and data-memory handshake
//   stall_*                     hold PC / pipeline registers (combinational)
//   flush_*                     load bubbles into pipeline registers (combinational)
//   mem_error                   sticky memory timeout
//   stall_cnt, flush_cnt        saturating cycle / flush counters
// ---------------------------------------------------------------------------
module detector_riesgos #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Ra_Dec,
  input  logic             RE_A_Dec,
  input  logic [3:0]       Rb_Dec,
  input  logic             RE_B_Dec,
  input  logic [3:0]       Robj_Reg_Exe,
  input  logic             WE_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  input  logic             branch_taken_Exe,
  input  logic             mem_RE_Exe_Mem,
  input  logic             mem_ready,
  output logic             stall_PC,
  output logic             stall_F_Reg,
  output logic             stall_Reg_Exe,
  output logic             stall_Exe_Mem,
  output logic             flush_F_Reg,
  output logic             flush_Reg_Exe,
  output logic             flush_Mem_WB,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,  // second-cycle fetch kill after a taken branch
    ST_WAIT  = 2'd2   // inside or just leaving a memory freeze
  } state_t;

  localparam logic [7:0]       TIMEOUT_V  = 8'(TIMEOUT);
  localparam logic [7:0]       TIMEOUT_M1 = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic loaduse;

  assign freeze  = mem_RE_Exe_Mem & ~mem_ready;
  assign loaduse = mem_RE_Reg_Exe & WE_Reg_Exe &
                   ((RE_A_Dec & (Ra_Dec == Robj_Reg_Exe)) |
                    (RE_B_Dec & (Rb_Dec == Robj_Reg_Exe)));

  // Pipeline controls. A freeze masks branch and load-use: those inputs are
  // simply re-evaluated once the memory releases the pipeline.
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    stall_PC      = 1'b0;
    stall_F_Reg   = 1'b0;
    stall_Reg_Exe = 1'b0;
    stall_Exe_Mem = 1'b0;
    flush_F_Reg   = 1'b0;
    flush_Reg_Exe = 1'b0;
    flush_Mem_WB  = 1'b0;
    if (!rst) begin
      if (freeze) begin
        stall_PC      = 1'b1;
        stall_F_Reg   = 1'b1;
        stall_Reg_Exe = 1'b1;
        stall_Exe_Mem = 1'b1;
        flush_Mem_WB  = 1'b1;
      end else if (state_q == ST_FLUSH) begin
        // Kill the fetch already in flight from synchronous instruction memory.
        flush_F_Reg = 1'b1;
      end else if (branch_taken_Exe) begin
        flush_F_Reg   = 1'b1;
        flush_Reg_Exe = 1'b1;
      end else if (loaduse) begin
        // One-cycle bubble; the load result then reaches Exe via Mem/WB forwarding.
        stall_PC      = 1'b1;
        stall_F_Reg   = 1'b1;
        flush_Reg_Exe = 1'b1;
      end
    end
  end

  // Next state. FLUSH holds through a freeze so the deferred fetch kill still
  // happens on the first released cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (freeze)                state_d = ST_WAIT;
        else if (branch_taken_Exe) state_d = ST_FLUSH;
        else                       state_d = ST_RUN;
      end
      ST_FLUSH: begin
        if (freeze) state_d = ST_FLUSH;
        else        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Timeout tracking and performance counters.
  always_comb begin
    wait_cnt_d  = 8'd0;
    mem_error_d = mem_error_q;
    if (freeze) begin
      wait_cnt_d = (wait_cnt_q >= TIMEOUT_V) ? TIMEOUT_V : wait_cnt_q + 8'd1;
      // This freeze cycle is the TIMEOUT-th in a row (or later).
      if (wait_cnt_q >= TIMEOUT_M1) mem_error_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_PC && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;

    flush_cnt_d = flush_cnt_q;
    if ((state_q != ST_FLUSH) && (state_d == ST_FLUSH) && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_error = mem_error_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
